urv_writeback: RTL and testbench

Writeback stage of the uRV pipeline, sitting directly upstream of the register file write port. Accepts one retiring instruction per cycle from execute and aligns and sign-extends load data returned by the data bus. Drives the register-file write port and its W-stage bypass path, and stalls the pipeline while a load or store is outstanding. A cycle watchdog aborts hung memory accesses.

---
 rtl/urv_writeback.sv | 107 ++++++++++
 tb/tb_urv_writeback.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/urv_writeback.sv
// urv_writeback: retires instructions, aligns load data, stalls on memory ops with a watchdog
module urv_writeback #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [1:0]  x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic        w_stall_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_store_o,
  output logic        rf_bypass_rd_write_o,
  output logic [31:0] rf_bypass_rd_value_o,
  output logic        w_bus_error_o
);
  typedef enum logic [1:0] {IDLE, WAIT_LOAD, WAIT_STORE} state_t;
  state_t state;
  logic [7:0]  cnt;
  logic [4:0]  rd_q;
  logic [2:0]  fun_q;
  logic [1:0]  addr_q;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] ld;
  logic        to;
  always_comb begin
    b  = addr_q[1] ? (addr_q[0] ? dm_data_l_i[31:24] : dm_data_l_i[23:16])
                   : (addr_q[0] ? dm_data_l_i[15:8]  : dm_data_l_i[7:0]);
    h  = addr_q[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
    ld = fun_q == 3'b000 ? {{24{b[7]}}, b} :
         fun_q == 3'b001 ? {{16{h[15]}}, h} :
         fun_q == 3'b100 ? {24'b0, b} :
         fun_q == 3'b101 ? {16'b0, h} : dm_data_l_i;
    to = cnt == 8'(TIMEOUT - 1);
  end
  assign rf_bypass_rd_write_o = rf_rd_store_o;
  assign rf_bypass_rd_value_o = rf_rd_value_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      rd_q          <= '0;
      fun_q         <= '0;
      addr_q        <= '0;
      w_stall_o     <= 1'b0;
      rf_rd_o       <= '0;
      rf_rd_value_o <= '0;
      rf_rd_store_o <= 1'b0;
      w_bus_error_o <= 1'b0;
    end else begin
      rf_rd_store_o <= 1'b0;
      w_bus_error_o <= 1'b0;
      case (state)
        IDLE: if (x_valid_i) begin
          if (x_load_i) begin
            state     <= WAIT_LOAD;
            cnt       <= '0;
            rd_q      <= x_rd_i;
            fun_q     <= x_fun_i;
            addr_q    <= x_dm_addr_i;
            w_stall_o <= 1'b1;
          end else if (x_store_i) begin
            state     <= WAIT_STORE;
            cnt       <= '0;
            w_stall_o <= 1'b1;
          end else if (x_rd_write_i && x_rd_i != 5'd0) begin
            rf_rd_store_o <= 1'b1;
            rf_rd_o       <= x_rd_i;
            rf_rd_value_o <= x_rd_value_i;
          end
        end
        WAIT_LOAD: if (dm_load_done_i) begin
          state     <= IDLE;
          w_stall_o <= 1'b0;
          if (rd_q != 5'd0) begin
            rf_rd_store_o <= 1'b1;
            rf_rd_o       <= rd_q;
            rf_rd_value_o <= ld;
          end
        end else if (to) begin
          state         <= IDLE;
          w_stall_o     <= 1'b0;
          w_bus_error_o <= 1'b1;
        end else cnt <= cnt + 8'd1;
        WAIT_STORE: if (dm_store_done_i) begin
          state     <= IDLE;
          w_stall_o <= 1'b0;
        end else if (to) begin
          state         <= IDLE;
          w_stall_o     <= 1'b0;
          w_bus_error_o <= 1'b1;
        end else cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_urv_writeback.sv
// tb_urv_writeback: scoreboard bench for urv_writeback with directed vectors
module tb_urv_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        x_valid, x_rd_write, x_load, x_store;
  logic [4:0]  x_rd;
  logic [31:0] x_rd_value;
  logic [2:0]  x_fun;
  logic [1:0]  x_addr;
  logic [31:0] dm_data;
  logic        dm_load_done, dm_store_done;
  logic        w_stall, rf_store, byp_write, bus_err;
  logic [4:0]  rf_rd;
  logic [31:0] rf_value, byp_value;
  typedef struct {logic err; logic [4:0] rd; logic [31:0] val;} exp_t;
  exp_t q[$];
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  urv_writeback #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_i(rst), .x_valid_i(x_valid), .x_rd_i(x_rd), .x_rd_value_i(x_rd_value),
    .x_rd_write_i(x_rd_write), .x_load_i(x_load), .x_store_i(x_store), .x_fun_i(x_fun),
    .x_dm_addr_i(x_addr), .dm_data_l_i(dm_data), .dm_load_done_i(dm_load_done),
    .dm_store_done_i(dm_store_done), .w_stall_o(w_stall), .rf_rd_o(rf_rd),
    .rf_rd_value_o(rf_value), .rf_rd_store_o(rf_store), .rf_bypass_rd_write_o(byp_write),
    .rf_bypass_rd_value_o(byp_value), .w_bus_error_o(bus_err)
  );
  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
  endfunction
  always @(negedge clk) if (!rst && (rf_store || bus_err)) begin
    if (q.size() == 0) chk("unexpected_event", {30'b0, bus_err, rf_store}, 32'd0);
    else begin
      exp_t e;
      e = q.pop_front();
      chk("sb_err", {31'b0, bus_err}, {31'b0, e.err});
      if (!e.err) begin
        chk("sb_rd", {27'b0, rf_rd}, {27'b0, e.rd});
        chk("sb_val", rf_value, e.val);
        chk("sb_byp_val", byp_value, e.val);
        chk("sb_byp_wr", {31'b0, byp_write}, 32'd1);
      end
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic alu(input logic [4:0] r, input logic [31:0] v);
    x_valid = 1; x_rd = r; x_rd_value = v; x_rd_write = 1;
    if (r != 0) q.push_back('{1'b0, r, v});
    tick;
    x_valid = 0; x_rd_write = 0;
  endtask
  task automatic do_load(input string n, input logic [2:0] f, input logic [1:0] a, input logic [4:0] r,
                         input logic [31:0] d, input int w, input logic [31:0] e);
    x_valid = 1; x_load = 1; x_fun = f; x_addr = a; x_rd = r;
    if (r != 0) q.push_back('{1'b0, r, e});
    tick;
    x_valid = 0; x_load = 0; x_fun = 0; x_addr = 0;
    for (int i = 1; i <= w; i++) begin
      chk({n, "_stall_hi"}, {31'b0, w_stall}, 32'd1);
      if (i < w) tick;
    end
    dm_data = d; dm_load_done = 1;
    tick;
    dm_load_done = 0; dm_data = 0;
    chk({n, "_stall_lo"}, {31'b0, w_stall}, 32'd0);
    chk({n, "_store"}, {31'b0, rf_store}, {31'b0, r != 0});
    chk({n, "_err"}, {31'b0, bus_err}, 32'd0);
  endtask
  initial begin
    rst = 1; x_valid = 0; x_rd = 0; x_rd_value = 0; x_rd_write = 0; x_load = 0; x_store = 0;
    x_fun = 0; x_addr = 0; dm_data = 0; dm_load_done = 0; dm_store_done = 0;
    tick; tick;
    chk("rst_store", {31'b0, rf_store}, 32'd0);
    chk("rst_byp", {31'b0, byp_write}, 32'd0);
    chk("rst_err", {31'b0, bus_err}, 32'd0);
    chk("rst_stall", {31'b0, w_stall}, 32'd0);
    chk("rst_rd", {27'b0, rf_rd}, 32'd0);
    chk("rst_val", rf_value, 32'd0);
    rst = 0;
    tick;
    alu(5'd5, 32'h12345678);
    chk("alu_pulse", {31'b0, rf_store}, 32'd1);
    chk("alu_stall", {31'b0, w_stall}, 32'd0);
    tick;
    chk("alu_one_cycle", {31'b0, rf_store}, 32'd0);
    chk("alu_hold_val", rf_value, 32'h12345678);
    alu(5'd0, 32'hDEADBEEF);
    chk("alu_x0", {31'b0, rf_store}, 32'd0);
    alu(5'd1, 32'h00000011);
    alu(5'd2, 32'h00000022);
    chk("b2b_second", {31'b0, rf_store}, 32'd1);
    tick;
    do_load("lb",  3'b000, 2'd2, 5'd7,  32'h00800000, 3, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 2'd2, 5'd7,  32'h00800000, 3, 32'h00000080);
    do_load("lhu", 3'b101, 2'd3, 5'd8,  32'hBEEF0000, 1, 32'h0000BEEF);
    do_load("lh",  3'b001, 2'd1, 5'd9,  32'h12348001, 2, 32'hFFFF8001);
    do_load("lb1", 3'b000, 2'd1, 5'd10, 32'h00007F00, 1, 32'h0000007F);
    do_load("lw",  3'b010, 2'd3, 5'd11, 32'hCAFEF00D, 1, 32'hCAFEF00D);
    do_load("und", 3'b111, 2'd1, 5'd12, 32'h80000001, 1, 32'h80000001);
    do_load("lx0", 3'b010, 2'd0, 5'd0,  32'h55555555, 1, 32'h0);
    do_load("race", 3'b000, 2'd3, 5'd13, 32'h81000000, 4, 32'hFFFFFF81);
    x_valid = 1; x_store = 1; x_load = 1; x_fun = 3'b010; x_rd = 5'd14;
    q.push_back('{1'b0, 5'd14, 32'h0BADF00D});
    tick;
    x_valid = 0; x_store = 0; x_load = 0; x_fun = 0;
    dm_store_done = 1;
    tick;
    dm_store_done = 0;
    chk("both_is_load_stall", {31'b0, w_stall}, 32'd1);
    dm_data = 32'h0BADF00D; dm_load_done = 1;
    tick;
    dm_load_done = 0; dm_data = 0;
    chk("both_is_load_store", {31'b0, rf_store}, 32'd1);
    x_valid = 1; x_store = 1;
    tick;
    x_store = 0; x_rd = 5'd3; x_rd_value = 32'h33; x_rd_write = 1;
    tick;
    x_valid = 0; x_rd_write = 0;
    chk("st_ignore_valid", {31'b0, rf_store}, 32'd0);
    chk("st_stall", {31'b0, w_stall}, 32'd1);
    dm_store_done = 1;
    tick;
    dm_store_done = 0;
    chk("st_done_stall", {31'b0, w_stall}, 32'd0);
    chk("st_done_nowrite", {31'b0, rf_store}, 32'd0);
    x_valid = 1; x_store = 1;
    q.push_back('{1'b1, 5'd0, 32'd0});
    tick;
    x_valid = 0; x_store = 0;
    for (int i = 1; i <= 4; i++) begin
      chk("to_stall_hi", {31'b0, w_stall}, 32'd1);
      chk("to_no_err", {31'b0, bus_err}, 32'd0);
      tick;
    end
    chk("to_stall_lo", {31'b0, w_stall}, 32'd0);
    chk("to_err", {31'b0, bus_err}, 32'd1);
    chk("to_nowrite", {31'b0, rf_store}, 32'd0);
    dm_store_done = 1;
    tick;
    dm_store_done = 0;
    chk("late_ack_err", {31'b0, bus_err}, 32'd0);
    chk("late_ack_stall", {31'b0, w_stall}, 32'd0);
    x_valid = 1; x_load = 1; x_rd = 5'd15;
    tick;
    x_valid = 0; x_load = 0;
    rst = 1;
    tick;
    rst = 0;
    chk("rst_wait_stall", {31'b0, w_stall}, 32'd0);
    dm_data = 32'h77777777; dm_load_done = 1;
    tick;
    dm_load_done = 0; dm_data = 0;
    chk("rst_wait_nowrite", {31'b0, rf_store}, 32'd0);
    chk("rst_wait_noerr", {31'b0, bus_err}, 32'd0);
    alu(5'd20, 32'hA5A5A5A5);
    chk("post_rst_alu", {31'b0, rf_store}, 32'd1);
    tick; tick;
    chk("sb_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
